// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES-128 round sequencer driving an external round datapath and round-key source.
// Define AES_ROUND_CTRL_ABORT_EN to add the i_abort input that cancels a run while waiting for a key.
module aes_round_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [127:0] i_data_in,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic         i_abort,
`endif
  output logic         o_busy,
  output logic         o_done,
  output logic [127:0] o_data_out,
  output logic         o_key_req,
  output logic [3:0]   o_key_round,
  input  logic         i_key_valid,
  input  logic [127:0] i_round_key,
  output logic [127:0] o_rnd_state,
  output logic         o_rnd_mix_en,
  input  logic [127:0] i_rnd_result
);
  typedef enum logic [1:0] {IDLE, KEY_WAIT, DONE} state_e;
  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] data_q, data_d, st_q, st_d, out_q, out_d, key_x;
  logic         abort;
`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort = i_abort;
`else
  assign abort = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    data_d  = data_q;
    st_d    = st_q;
    out_d   = out_q;
    key_x   = (rnd_q == 4'd0 ? data_q : i_rnd_result) ^ i_round_key;
    case (state_q)
      IDLE: if (i_start) begin
        state_d = KEY_WAIT;
        rnd_d   = 4'd0;
        data_d  = i_data_in;
      end
      KEY_WAIT: if (abort) begin
        state_d = IDLE;
        rnd_d   = 4'd0;
      end else if (i_key_valid) begin
        if (rnd_q == 4'd10) begin
          out_d   = key_x;
          state_d = DONE;
        end else begin
          st_d  = key_x;
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        rnd_d   = 4'd0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      data_q  <= '0;
      st_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      data_q  <= data_d;
      st_q    <= st_d;
      out_q   <= out_d;
    end
  assign o_busy       = state_q != IDLE;
  assign o_done       = state_q == DONE;
  assign o_key_req    = state_q == KEY_WAIT;
  assign o_key_round  = rnd_q;
  assign o_data_out   = out_q;
  assign o_rnd_state  = st_q;
  assign o_rnd_mix_en = rnd_q != 4'd10;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed bench with an AES-128 round/key-schedule model as the external datapath.
module tb_aes_round_ctrl;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic         clk = 0, rst_n = 0, i_start = 0, i_key_valid = 0;
  logic         o_busy, o_done, o_key_req, o_rnd_mix_en;
  logic [127:0] i_data_in = '0, o_data_out, i_round_key, o_rnd_state, i_rnd_result;
  logic [3:0]   o_key_round;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic         i_abort = 0;
`endif
  logic [127:0] rk [16];
  logic [31:0]  w [44];
  int n_tests = 0, n_fail = 0;
  int dc, cnt, ec;
  always #5 clk = ~clk;
  aes_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_data_in(i_data_in),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .i_abort(i_abort),
`endif
    .o_busy(o_busy), .o_done(o_done), .o_data_out(o_data_out),
    .o_key_req(o_key_req), .o_key_round(o_key_round), .i_key_valid(i_key_valid),
    .i_round_key(i_round_key), .o_rnd_state(o_rnd_state), .o_rnd_mix_en(o_rnd_mix_en),
    .i_rnd_result(i_rnd_result)
  );
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, b);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [7:0]   a [4];
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127-8*(4*c+k) -: 8];
      r[127-32*c -: 32] = {xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3],
                           a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3],
                           a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3],
                           xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3])};
    end
    return r;
  endfunction
  function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic mix);
    logic [127:0] t;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return mix ? mix_cols(t) : t;
  endfunction
  assign i_rnd_result = aes_rnd(o_rnd_state, o_rnd_mix_en);
  assign i_round_key  = rk[o_key_round];
  task automatic key_expand();
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = r < 11 ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_key_req"}, o_key_req, 0);
    check({tag, "_key_round"}, o_key_round, 0);
    check({tag, "_data_out"}, o_data_out, 0);
    check({tag, "_rnd_state"}, o_rnd_state, 0);
  endtask
  // Called at a falling edge; the following rising edge is cycle 0 (start accept).
  // A value sampled at a falling edge is labelled with the number of the next rising edge.
  task automatic run_op(input int stall, input int sa, input int sb, input int stop_at, input int abort_at,
                        output int done_cyc, output int done_cnt, output int end_cyc);
    int n, wc, er;
    n = 0; wc = 0; er = 0; done_cyc = -1; done_cnt = 0; end_cyc = -1;
    i_data_in   = PT;
    i_start     = 1;
    i_key_valid = stall == 0;
    @(posedge clk);
    for (int it = 0; it < 100; it++) begin
      @(negedge clk);
      n++;
      if (o_done) begin
        done_cnt++;
        done_cyc = n;
      end
      if (n == 1) check("busy_after_start", o_busy, 1);
      if (o_key_req) begin
        check("key_round", o_key_round, er);
        check("mix_en", o_rnd_mix_en, er != 10);
      end
      if (stall == 0 && n == 2) check("state_round1", o_rnd_state, 128'h00102030405060708090a0b0c0d0e0f0);
      if (stall == 0 && n == 3) check("state_round2", o_rnd_state, 128'h89d810e8855ace682d1843d8cb128fe4);
      if ((n > 1 && !o_busy) || n == stop_at) begin
        end_cyc = n;
        break;
      end
      i_start = n == sa || n == sb;
      if (stall == 0) i_key_valid = 1;
      else begin
        i_key_valid = o_key_req && wc == stall;
        wc = (o_key_req && wc < stall) ? wc + 1 : 0;
      end
      if (o_key_req && i_key_valid) er++;
`ifdef AES_ROUND_CTRL_ABORT_EN
      i_abort = n == abort_at;
`endif
    end
    if (end_cyc < 0) check("timeout", 1, 0);
    i_start = 0;
    i_key_valid = 0;
`ifdef AES_ROUND_CTRL_ABORT_EN
    i_abort = 0;
`endif
  endtask
  initial begin
    key_expand();
    #1 rst_n = 1;
    #1 check_reset_outputs("por");
    check("mixcol_model", mix_cols(128'hd4bf5d30e0b452aeb84111f11e2798e5), 128'h046681e5e0cb199a48f8d37a2806264c);
    repeat (2) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    run_op(0, 0, 0, 0, 0, dc, cnt, ec);
    check("fips_ct", o_data_out, CT);
    check("fips_done_cyc", dc, 12);
    check("fips_done_cnt", cnt, 1);
    check("fips_idle_cyc", ec, 13);
    run_op(0, 0, 0, 0, 0, dc, cnt, ec);
    check("b2b_ct", o_data_out, CT);
    check("b2b_done_cyc", dc, 12);
    check("b2b_done_cnt", cnt, 1);
    @(negedge clk);
    run_op(3, 0, 0, 0, 0, dc, cnt, ec);
    check("stall_ct", o_data_out, CT);
    check("stall_done_cyc", dc, 45);
    check("stall_done_cnt", cnt, 1);
    @(negedge clk);
    run_op(0, 5, 9, 0, 0, dc, cnt, ec);
    check("restart_ign_ct", o_data_out, CT);
    check("restart_ign_done_cyc", dc, 12);
    check("restart_ign_done_cnt", cnt, 1);
    @(negedge clk);
    run_op(0, 0, 0, 6, 0, dc, cnt, ec);
    check("rst_stop_cyc", ec, 6);
    rst_n = 1;
    #1 check_reset_outputs("mid_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_done", o_done, 0);
    end
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_no_done", o_done, 0);
    end
    check("rst_run_done_cnt", cnt, 0);
    run_op(0, 0, 0, 0, 0, dc, cnt, ec);
    check("post_rst_ct", o_data_out, CT);
    check("post_rst_done_cyc", dc, 12);
    check("post_rst_done_cnt", cnt, 1);
`ifdef AES_ROUND_CTRL_ABORT_EN
    @(negedge clk);
    run_op(0, 0, 0, 0, 4, dc, cnt, ec);
    check("abort_idle_cyc", ec, 5);
    check("abort_done_cnt", cnt, 0);
    check("abort_data_kept", o_data_out, CT);
    check("abort_key_req", o_key_req, 0);
    @(negedge clk);
    run_op(0, 0, 0, 0, 0, dc, cnt, ec);
    check("post_abort_ct", o_data_out, CT);
    check("post_abort_done_cyc", dc, 12);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
